rx_data_capture: RTL

//  Datapath stage directly downstream of the UART Rx FSM: shifts serial bits in during data states,

---
 rtl/rx_data_capture_pkg.sv | 17 +
 rtl/rx_parity_checker.sv | 20 ++
 rtl/rx_data_capture.sv | 118 +++++++++++
 3 files changed

// File: rtl/rx_data_capture_pkg.sv
// Shared constants for the UART receive path: FSM state encodings, default frame width, parity types.
package rx_data_capture_pkg;

    localparam int RX_DEFAULT_DATA_WIDTH = 8;

    localparam int RX_PARITY_EVEN = 0;
    localparam int RX_PARITY_ODD  = 1;

    typedef enum logic [2:0] {
        RX_ST_IDLE   = 3'd0,
        RX_ST_START  = 3'd1,
        RX_ST_DATA   = 3'd2,
        RX_ST_PARITY = 3'd3,
        RX_ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_parity_checker.sv
// Combinational parity check: flags a mismatch between the received parity bit and the data word.
module rx_parity_checker
    import rx_data_capture_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DEFAULT_DATA_WIDTH,
    parameter int PARITY_ODD = RX_PARITY_EVEN
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  parity_rx,
    output logic                  mismatch
);

    logic expected;

    always_comb begin
        expected = (^data) ^ (PARITY_ODD != 0);
        mismatch = parity_rx ^ expected;
    end

endmodule

// File: rtl/rx_data_capture.sv
// UART Rx datapath: shifts data bits LSB-first, captures parity, presents the byte through a valid/ready holding register.
// Optional build macro RX_OVERRUN_STICKY_EN makes overrun hold until reset instead of pulsing for one cycle.
module rx_data_capture
    import rx_data_capture_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = RX_DEFAULT_DATA_WIDTH,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_ODD       = RX_PARITY_EVEN
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    input  logic                        sampling_strobe,
    input  logic                        data_is_available,
    input  logic                        is_parity_stage,
    input  logic                        data_is_valid,
    output logic [INPUT_DATA_WIDTH-1:0] rx_data_out,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        parity_error,
    output logic                        overrun
);

    localparam int W     = INPUT_DATA_WIDTH;
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);

    logic [W-1:0]     shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             parity_rx_q, parity_rx_d;
    logic [W-1:0]     rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             parity_error_q, parity_error_d;
    logic             overrun_q, overrun_d;

    logic mismatch;
    logic frame_done;
    logic can_load;
    logic drop;

    rx_parity_checker #(
        .DATA_WIDTH (W),
        .PARITY_ODD (PARITY_ODD)
    ) u_parity (
        .data      (shift_reg_q),
        .parity_rx (parity_rx_q),
        .mismatch  (mismatch)
    );

    always_comb begin
        shift_reg_d    = shift_reg_q;
        bit_cnt_d      = bit_cnt_q;
        parity_rx_d    = parity_rx_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = rx_valid_q;
        parity_error_d = parity_error_q;

        frame_done = data_is_valid && (bit_cnt_q == CNT_FULL);
        can_load   = !rx_valid_q || rx_ready;
        drop       = frame_done && !can_load;

        if (sampling_strobe && data_is_available) begin
            shift_reg_d = {serial_in, shift_reg_q[W-1:1]};
            if (bit_cnt_q != CNT_FULL) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
        if (sampling_strobe && is_parity_stage) begin
            parity_rx_d = serial_in;
        end

        // Any end-of-frame pulse restarts the frame, including truncated ones.
        if (data_is_valid) begin
            bit_cnt_d   = '0;
            parity_rx_d = 1'b0;
        end

        if (frame_done && can_load) begin
            rx_valid_d     = 1'b1;
            rx_data_d      = shift_reg_q;
            parity_error_d = (PARITY_ENABLED != 0) && mismatch;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

`ifdef RX_OVERRUN_STICKY_EN
        overrun_d = overrun_q || drop;
`else
        overrun_d = drop;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg_q    <= '0;
            bit_cnt_q      <= '0;
            parity_rx_q    <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            parity_error_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            shift_reg_q    <= shift_reg_d;
            bit_cnt_q      <= bit_cnt_d;
            parity_rx_q    <= parity_rx_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            parity_error_q <= parity_error_d;
            overrun_q      <= overrun_d;
        end
    end

    assign rx_data_out  = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign parity_error = parity_error_q;
    assign overrun      = overrun_q;

endmodule
